music_player: RTL
=================

MUSIC_PLAYER -- requirements
Module: music_player

Interface
REQ-001 SHALL have parameter BEAT_DIV, default 16_666_667, giving clk100mhz cycles per score position (about 6 Hz).
REQ-002 SHALL have parameter GAP_DIV, default 2_083_333, giving the number of silent cycles at the end of each beat.
REQ-003 SHALL have port clk100mhz, input, 1 bit: the single clock.
REQ-004 SHALL have port clr, input, 1 bit: reset, asynchronous and active-low.
REQ-005 SHALL have port start, input, 1 bit: single-cycle pulse that begins playback at position 0.
REQ-006 SHALL have port stop, input, 1 bit: single-cycle pulse that aborts playback.
REQ-007 SHALL have port pause, input, 1 bit: level; freezes playback and mutes output while high.
REQ-008 SHALL have port loop, input, 1 bit: level; replay from position 0 after the last position.
REQ-009 SHALL have port rhyme, input, 301 bits: note nibble per position, where position p is bits [4p+3:4p].
REQ-010 SHALL have port md, input, 301 bits: octave nibble per position, same layout as rhyme.
REQ-011 SHALL have port how_long, input, 8 bits: score length in positions.
REQ-012 SHALL have port buzzer, output, 1 bit: registered square-wave tone.
REQ-013 SHALL have port play_pos, output, 8 bits: current position.
REQ-014 SHALL have port cur_note, output, 4 bits: latched note of the current beat.
REQ-015 SHALL have port cur_md, output, 4 bits: latched octave of the current beat.
REQ-016 SHALL have port playing, output, 1 bit: high in PLAY and PAUSE.
REQ-017 SHALL have port done, output, 1 bit: one-cycle pulse at natural end of score.

Function
REQ-018 FSM states SHALL be IDLE, PLAY and PAUSE.
REQ-019 IDLE -> PLAY SHALL occur on start when the effective length is nonzero; a start with length 0 SHALL be ignored.
REQ-020 Effective length SHALL be min(how_long, 75).
REQ-021 On entering PLAY: play_pos=0, beat counter=0, tone counter=0; cur_note and cur_md SHALL latch the position-0 nibbles in the same cycle.
REQ-022 A start received during PLAY or PAUSE SHALL restart playback at position 0.
REQ-023 stop SHALL force IDLE from any state with play_pos=0 and no done pulse; when stop and start arrive together, stop SHALL win.
REQ-024 PLAY -> PAUSE SHALL occur while pause=1, and PAUSE -> PLAY when pause=0; in PAUSE, beat and tone counters SHALL hold and buzzer SHALL be 0.
REQ-025 The beat counter SHALL count 0..BEAT_DIV-1; at terminal count, play_pos SHALL advance and cur_note/cur_md SHALL latch the new position's nibbles.
REQ-026 rhyme and md changes during a beat SHALL have no effect until the next latch.
REQ-027 At terminal count of the last position (len-1): with loop=1, play_pos SHALL wrap to 0 and no done pulse SHALL be produced.
REQ-028 At terminal count of the last position with loop=0: the block SHALL go to IDLE, set play_pos=0 and assert done for exactly one cycle.
REQ-029 Note decode: 1..7 SHALL map to do..si; 0 and 8..15 SHALL be rests.
REQ-030 Mid-octave half-periods SHALL be 191113, 170262, 151686, 143173, 127551, 113636 and 101239 cycles for notes 1..7.
REQ-031 Octave decode: md=1 SHALL use half-period<<1 (low); md=2 SHALL use half-period>>1 (high); any other md value SHALL use mid.
REQ-032 Half-period arithmetic SHALL be 20 bits unsigned.
REQ-033 The tone counter SHALL count 0..half-1, toggling an internal square wave at half-1; the counter and square wave SHALL reset to 0 at every beat boundary.
REQ-034 buzzer SHALL equal square AND state==PLAY AND note in 1..7 AND beat counter < BEAT_DIV-GAP_DIV, registered with 1 cycle latency.

Reset
REQ-035 While clr=0, the block SHALL be in IDLE and every output (buzzer, play_pos, cur_note, cur_md, playing, done) and every counter SHALL be 0, asynchronously, including mid-playback.
REQ-036 After clr rises, the block SHALL wait in IDLE for start.

Structure
REQ-037 Package music_pkg SHALL hold the state enum, MAX_POS=75, the 7-entry mid half-period table and the octave codes LOW=1 and HIGH=2.
REQ-038 Sub-module tone_gen SHALL implement the half-period counter and toggle, with inputs half_period, enable and sync_clear.

Verification (BEAT_DIV=1_000_000, GAP_DIV=125_000)
REQ-039 Scenario: pos0 note 6, md 0, how_long=1, start -> buzzer rises 113637 cycles after start, period 227272, forced 0 from beat cycle 875000; done at cycle 1_000_000; playing drops.
REQ-040 Scenario: note 1 with md=2 -> half-period 95556; with md=1 -> 382226; note 0 -> buzzer stays 0 for the whole beat.
REQ-041 Scenario: how_long=3, loop=0 -> play_pos 0,1,2 at beats 0..2, exactly one done pulse; with loop=1 -> 2 wraps to 0, no done.
REQ-042 Scenario: pause high for 500_000 cycles mid-beat -> buzzer 0 and play_pos frozen; the next advance is delayed by exactly 500_000 cycles.
REQ-043 Scenario: how_long=0 plus start -> stays IDLE; stop and start in the same cycle -> IDLE; how_long=200 -> play_pos wraps/ends after 74.
REQ-044 Scenario: clr low during PLAY -> all outputs 0 in the same cycle without a clock edge; no done pulse after release.

Source files
------------

// File: rtl/music_pkg.sv
// Shared types and constants for the score player: FSM states, score limits,
// the mid-octave half-period table and octave decode.
package music_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        PLAY  = 2'd1,
        PAUSE = 2'd2
    } state_e;

    localparam int MAX_POS = 75;

    localparam logic [3:0] LOW  = 4'd1;
    localparam logic [3:0] HIGH = 4'd2;

    // Half-periods in clk100mhz cycles for do..si, mid octave.
    localparam logic [19:0] MID_HALF [7] = '{
        20'd191113, 20'd170262, 20'd151686, 20'd143173,
        20'd127551, 20'd113636, 20'd101239
    };

    function automatic logic note_valid(input logic [3:0] n);
        return (n >= 4'd1) && (n <= 4'd7);
    endfunction

    function automatic logic [19:0] note_half(input logic [3:0] n, input logic [3:0] oct);
        logic [19:0] half;
        logic [2:0]  idx;
        idx  = 3'(n - 4'd1);
        half = 20'd0;
        if (note_valid(n)) begin
            half = MID_HALF[idx];
        end
        case (oct)
            LOW:     half = half << 1;
            HIGH:    half = half >> 1;
            default: ;
        endcase
        return half;
    endfunction

endpackage

// File: rtl/tone_gen.sv
// Square-wave generator: counts 0..half_period-1 and toggles at the top.
// sync_clear restarts the wave in phase with the beat.
module tone_gen
    import music_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic [19:0] half_period,
    input  logic        enable,
    input  logic        sync_clear,
    output logic        square
);

    logic [19:0] cnt_q, cnt_d;
    logic        sq_q, sq_d;

    always_comb begin
        cnt_d = cnt_q;
        sq_d  = sq_q;
        if (sync_clear) begin
            cnt_d = '0;
            sq_d  = 1'b0;
        end else if (enable && (half_period != 20'd0)) begin
            if (cnt_q >= half_period - 20'd1) begin
                cnt_d = '0;
                sq_d  = ~sq_q;
            end else begin
                cnt_d = cnt_q + 20'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
            sq_q  <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            sq_q  <= sq_d;
        end
    end

    assign square = sq_q;

endmodule

// File: rtl/music_player.sv
// Score player: steps through up to 75 note/octave nibbles, one per beat,
// driving a gated square-wave buzzer with a silent gap at the end of each beat.
module music_player
    import music_pkg::*;
#(
    parameter int unsigned BEAT_DIV = 16_666_667,
    parameter int unsigned GAP_DIV  = 2_083_333
) (
    input  logic         clk100mhz,
    input  logic         clr,
    input  logic         start,
    input  logic         stop,
    input  logic         pause,
    input  logic         loop,
    input  logic [300:0] rhyme,
    input  logic [300:0] md,
    input  logic [7:0]   how_long,
    output logic         buzzer,
    output logic [7:0]   play_pos,
    output logic [3:0]   cur_note,
    output logic [3:0]   cur_md,
    output logic         playing,
    output logic         done
);

    localparam int BW = $clog2(BEAT_DIV + 1);
    localparam logic [BW-1:0] BEAT_LAST = BW'(BEAT_DIV - 1);
    localparam logic [BW-1:0] ON_CYC    = BW'(BEAT_DIV - GAP_DIV);

    state_e        state_q, state_d;
    logic [7:0]    pos_q, pos_d;
    logic [BW-1:0] beat_q, beat_d;
    logic [3:0]    note_q, note_d;
    logic [3:0]    oct_q, oct_d;
    logic          done_q, done_d;
    logic          buz_q, buz_d;

    logic [7:0]    eff_len;
    logic          start_ok, run, last, latch, tone_clr, square;
    logic [19:0]   half_w;
    logic          unused_bits;

    assign eff_len  = (how_long > 8'(MAX_POS)) ? 8'(MAX_POS) : how_long;
    assign start_ok = start && (eff_len != 8'd0);
    // Counters only move on cycles where pause is low, so a pause of N cycles
    // delays the beat by exactly N cycles.
    assign run      = (state_q != IDLE) && !pause;
    assign last     = (pos_q + 8'd1) >= eff_len;
    assign unused_bits = rhyme[300] ^ md[300];

    always_comb begin
        state_d  = state_q;
        pos_d    = pos_q;
        beat_d   = beat_q;
        note_d   = note_q;
        oct_d    = oct_q;
        done_d   = 1'b0;
        latch    = 1'b0;
        tone_clr = 1'b0;
        if (stop) begin
            state_d  = IDLE;
            pos_d    = '0;
            beat_d   = '0;
            tone_clr = 1'b1;
        end else if (start_ok) begin
            state_d  = PLAY;
            pos_d    = '0;
            beat_d   = '0;
            latch    = 1'b1;
            tone_clr = 1'b1;
        end else if (state_q != IDLE) begin
            state_d = pause ? PAUSE : PLAY;
            if (run) begin
                if (beat_q == BEAT_LAST) begin
                    beat_d   = '0;
                    tone_clr = 1'b1;
                    if (!last) begin
                        pos_d = pos_q + 8'd1;
                        latch = 1'b1;
                    end else if (loop) begin
                        pos_d = '0;
                        latch = 1'b1;
                    end else begin
                        state_d = IDLE;
                        pos_d   = '0;
                        done_d  = 1'b1;
                    end
                end else begin
                    beat_d = beat_q + 1'b1;
                end
            end
        end else begin
            tone_clr = 1'b1;
        end
        if (latch) begin
            note_d = rhyme[{pos_d, 2'b00} +: 4];
            oct_d  = md[{pos_d, 2'b00} +: 4];
        end
    end

    assign half_w = note_half(note_q, oct_q);

    tone_gen u_tone (
        .clk        (clk100mhz),
        .rst_n      (clr),
        .half_period(half_w),
        .enable     (run && note_valid(note_q)),
        .sync_clear (tone_clr),
        .square     (square)
    );

    assign buz_d = square && (state_q == PLAY) && note_valid(note_q) && (beat_q < ON_CYC);

    always_ff @(posedge clk100mhz or negedge clr) begin
        if (!clr) begin
            state_q <= IDLE;
            pos_q   <= '0;
            beat_q  <= '0;
            note_q  <= '0;
            oct_q   <= '0;
            done_q  <= 1'b0;
            buz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pos_q   <= pos_d;
            beat_q  <= beat_d;
            note_q  <= note_d;
            oct_q   <= oct_d;
            done_q  <= done_d;
            buz_q   <= buz_d;
        end
    end

    assign buzzer   = buz_q;
    assign play_pos = pos_q;
    assign cur_note = note_q;
    assign cur_md   = oct_q;
    assign playing  = (state_q != IDLE);
    assign done     = done_q;

endmodule
